// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, sequencer state encoding and strobe bundle for the CPU control unit.
package cpu_ctrl_pkg;

    localparam int OP_W = 5;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [2:0] STEP_FIRST = 3'd3;

    typedef enum logic [2:0] {
        S_RESET, S_T0, S_T1, S_T2, S_EXEC, S_HALT
    } state_e;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc;
        logic mar_in, mdr_in, mdr_out, mem_read, ram_enable;
        logic gra, grb, grc, r_in, r_out, ba_out, c_out;
        logic y_in, z_in, zlow_out, zhigh_out, hi_out, lo_out;
        logic op_add, op_sub, op_and, op_or;
        logic ir_in, inport_out, outport_in, run;
    } ctrl_t;

    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: last_step = 3'd5;
            OP_LD, OP_ST:                                   last_step = 3'd7;
            default:                                        last_step = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from sequencer state, execute step and opcode.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] step_i,
    input  logic [4:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.run = 1'b1; ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1; ctrl_o.z_in = 1'b1;
            end
            S_T1: begin
                ctrl_o.run = 1'b1; ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = 1'b1;
                ctrl_o.mem_read = 1'b1; ctrl_o.ram_enable = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.run = 1'b1; ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            S_EXEC: if (step_i >= STEP_FIRST) begin
                ctrl_o.run = 1'b1;
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        case (step_i)
                            3'd3: begin ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1; end
                            3'd4: begin
                                ctrl_o.z_in   = 1'b1;
                                ctrl_o.grc    = (opcode_i != OP_ADDI);
                                ctrl_o.r_out  = (opcode_i != OP_ADDI);
                                ctrl_o.c_out  = (opcode_i == OP_ADDI);
                                ctrl_o.op_add = (opcode_i == OP_ADD) || (opcode_i == OP_ADDI);
                                ctrl_o.op_sub = (opcode_i == OP_SUB);
                                ctrl_o.op_and = (opcode_i == OP_AND);
                                ctrl_o.op_or  = (opcode_i == OP_OR);
                            end
                            3'd5: begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ldi/ld/st share the base+offset address computation
                    OP_LDI, OP_LD, OP_ST: begin
                        case (step_i)
                            3'd3: begin ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1; end
                            3'd4: begin ctrl_o.c_out = 1'b1; ctrl_o.op_add = 1'b1; ctrl_o.z_in = 1'b1; end
                            3'd5: begin
                                ctrl_o.zlow_out = 1'b1;
                                ctrl_o.gra      = (opcode_i == OP_LDI);
                                ctrl_o.r_in     = (opcode_i == OP_LDI);
                                ctrl_o.mar_in   = (opcode_i != OP_LDI);
                            end
                            3'd6: begin
                                ctrl_o.mdr_in     = (opcode_i != OP_LDI);
                                ctrl_o.mem_read   = (opcode_i == OP_LD);
                                ctrl_o.ram_enable = (opcode_i == OP_LD);
                                ctrl_o.gra        = (opcode_i == OP_ST);
                                ctrl_o.r_out      = (opcode_i == OP_ST);
                            end
                            3'd7: begin
                                ctrl_o.mdr_out    = (opcode_i == OP_LD);
                                ctrl_o.gra        = (opcode_i == OP_LD);
                                ctrl_o.r_in       = (opcode_i == OP_LD);
                                ctrl_o.ram_enable = (opcode_i == OP_ST);
                            end
                            default: ;
                        endcase
                    end
                    OP_IN:   if (step_i == 3'd3) begin ctrl_o.gra = 1'b1; ctrl_o.r_in  = 1'b1; ctrl_o.inport_out = 1'b1; end
                    OP_OUT:  if (step_i == 3'd3) begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1; end
                    OP_MFHI: if (step_i == 3'd3) begin ctrl_o.gra = 1'b1; ctrl_o.r_in  = 1'b1; ctrl_o.hi_out = 1'b1; end
                    OP_MFLO: if (step_i == 3'd3) begin ctrl_o.gra = 1'b1; ctrl_o.r_in  = 1'b1; ctrl_o.lo_out = 1'b1; end
                    OP_JR:   if (step_i == 3'd3) begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in  = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the CPU datapath control strobes.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic PCout, PCin, IncPC,
    output logic MARin, MDRin, MDRout, memRead, ramEnable,
    output logic Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic Yin, Zin, Zlowout, Zhighout, HIout, LOout,
    output logic ADD, SUB, AND, OR,
    output logic IRin, InPort_Out, OutPort_In,
    output logic Run
);

    state_e           state_q;
    logic [2:0]       step_q;
    logic [OPW-1:0]   opcode;
    logic             unused_ir_bits;
    ctrl_t            ctrl;

    assign opcode         = IR[31 -: OPW];
    assign unused_ir_bits = ^IR[31-OPW:0];

    // RESET: idle after clear | T0-T2: fetch | EXEC: steps 3..7 | HALT: parked until clear
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RESET;
            step_q  <= 3'd0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_T0;
                S_T0:    state_q <= S_T1;
                S_T1:    state_q <= S_T2;
                S_T2: begin
                    state_q <= S_EXEC;
                    step_q  <= STEP_FIRST;
                end
                S_EXEC: begin
                    if (step_q < STEP_FIRST)
                        state_q <= S_T0;
                    else if (opcode == OP_HALT)
                        state_q <= S_HALT;
                    else if (step_q >= last_step(opcode))
                        state_q <= S_T0;
                    else
                        step_q <= step_q + 3'd1;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RESET;
            endcase
        end
    end

    control_decode u_decode (
        .state_i  (state_q),
        .step_i   (step_q),
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    assign PCout       = ctrl.pc_out;
    assign PCin        = ctrl.pc_in;
    assign IncPC       = ctrl.inc_pc;
    assign MARin       = ctrl.mar_in;
    assign MDRin       = ctrl.mdr_in;
    assign MDRout      = ctrl.mdr_out;
    assign memRead     = ctrl.mem_read;
    assign ramEnable   = ctrl.ram_enable;
    assign Gra         = ctrl.gra;
    assign Grb         = ctrl.grb;
    assign Grc         = ctrl.grc;
    assign Rin         = ctrl.r_in;
    assign Rout        = ctrl.r_out;
    assign BAout       = ctrl.ba_out;
    assign Cout        = ctrl.c_out;
    assign Yin         = ctrl.y_in;
    assign Zin         = ctrl.z_in;
    assign Zlowout     = ctrl.zlow_out;
    assign Zhighout    = ctrl.zhigh_out;
    assign HIout       = ctrl.hi_out;
    assign LOout       = ctrl.lo_out;
    assign ADD         = ctrl.op_add;
    assign SUB         = ctrl.op_sub;
    assign AND         = ctrl.op_and;
    assign OR          = ctrl.op_or;
    assign IRin        = ctrl.ir_in;
    assign InPort_Out  = ctrl.inport_out;
    assign OutPort_In  = ctrl.outport_in;
    assign Run         = ctrl.run;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the RISC CPU datapath. It generates the per-step control strobes that the Phase 2 benches drive by hand, such as `Gra`/`Rin`/`HIout` for `mfhi`. The sequencer covers instruction fetch, decode from `IR`, and execute for the supported opcodes. It sits beside the `CPU` datapath, takes `IR` as input, and drives the matching control-port names one-for-one.

## Interface
Parameters:
- `OPW`, default 5: opcode field width, `IR[31:27]`.

Ports (widths are 1 unless stated):
- `clock`  in  1  system clock; the state register advances on the rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `IR`  in  32  instruction register contents; only `IR[31:27]` is used.
- `PCout`, `PCin`, `IncPC`  out  PC control.
- `MARin`, `MDRin`, `MDRout`, `memRead`, `ramEnable`  out  memory path control.
  - `ramEnable` without `memRead` means a write.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout`  out  register-select and immediate control.
- `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIout`, `LOout`  out  ALU staging.
  - `Zhighout` is always 0 in this block.
- `ADD`, `SUB`, `AND`, `OR`  out  ALU operation select; one-hot or all 0.
- `IRin`, `InPort_Out`, `OutPort_In`  out  IR load and I/O port control.
- `Run`  out  1 while executing; 0 in RESET and HALT.

## Operation
- Control is a Moore FSM plus a step counter.
- States are RESET, T0, T1, T2, EXEC and HALT. EXEC holds a 3-bit step value of 3 to 7.
- Outputs are decoded combinationally from the state, the step and `IR[31:27]`.
- `IR` is loaded at the end of T2, so it is stable throughout EXEC.
- Opcodes:
  - `ld` 00000, `ldi` 00001, `st` 00010
  - `add` 00011, `sub` 00100, `and` 00101, `or` 00110
  - `addi` 01100, `jr` 10101
  - `in` 10110, `out` 10111
  - `mfhi` 11000, `mflo` 11001
  - `nop` 11010, `halt` 11011
  - Every other opcode executes as `nop`.
- Fetch:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `memRead`, `ramEnable`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- `add`, `sub`, `and`, `or`:
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Grc`, `Rout`, op strobe, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`.
- `addi`:
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Cout`, `ADD`, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`.
- `ldi`:
  - T3: `Grb`, `BAout`, `Yin`.
  - T4: `Cout`, `ADD`, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`.
- `ld`:
  - T3–T5 as `ldi`, except T5 is `Zlowout`, `MARin`.
  - T6: `memRead`, `ramEnable`, `MDRin`.
  - T7: `MDRout`, `Gra`, `Rin`.
- `st`:
  - T3–T5 as `ld`.
  - T6: `Gra`, `Rout`, `MDRin`.
  - T7: `ramEnable` only.
- Single-step instructions, all at T3:
  - `in`: `Gra`, `Rin`, `InPort_Out`.
  - `out`: `Gra`, `Rout`, `OutPort_In`.
  - `mfhi`: `Gra`, `Rin`, `HIout`.
  - `mflo`: `Gra`, `Rin`, `LOout`.
  - `jr`: `Gra`, `Rout`, `PCin`.
  - `nop`: no strobes.
- `halt`: T3 asserts no strobes and moves to HALT. HALT holds `Run`=0 and all strobes 0 until `clear`.

## Timing
- Each state or step lasts exactly one clock.
- Next-state rules:
  - RESET → T0 → T1 → T2 → EXEC with step 3.
  - In EXEC, the last step of the instruction returns to T0; any other step increments the step value.
- Last step per instruction:
  - step 5 for `add`, `sub`, `and`, `or`, `addi`, `ldi`.
  - step 7 for `ld`, `st`.
  - step 3 for everything else.
- Instruction lengths in cycles, including fetch: ALU, `addi`, `ldi` = 6; `ld`, `st` = 8; single-step instructions = 4.
- Reset:
  - `clear`=1 forces RESET immediately, regardless of the clock.
  - In RESET every output is 0, including `Run`.
  - Asserting `clear` mid-instruction aborts it, and no further strobes are issued.
  - The first rising edge after `clear` falls enters T0.
- At most one of `ADD`/`SUB`/`AND`/`OR` is 1 in any cycle.
- `Gra`/`Grb`/`Grc` are mutually exclusive.
- The step value never exceeds 7. An out-of-range step decodes to all-0 outputs and returns to T0.

## Structure
- Package `cpu_ctrl_pkg`:
  - opcode localparams;
  - state enum (RESET, T0, T1, T2, EXEC, HALT);
  - last-step function per opcode.
- Sub-module `control_decode`: purely combinational (state, step, opcode) → strobe vector. `control_unit` holds only the state/step registers and next-state logic.

## Test plan
- Reset mid-instruction: assert `clear` during step 4 of `add` → all outputs 0 immediately; T0 strobes appear on the first cycle after release.
- `mfhi`, `IR`=32'hC3000000 → cycles T0–T2 show the fetch strobes; cycle 4 shows `Gra`, `Rin`, `HIout` only; cycle 5 is T0 again.
- `add`, `IR`=32'h18000000 → 6-cycle sequence; `ADD` high only in cycle 5, together with `Grc`, `Rout`, `Zin`.
- `ld`, `IR`=32'h00000000, then `st`, `IR`=32'h10000000:
  - `ld` takes 8 cycles, with `memRead` in T1 and T6.
  - `st` shows `ramEnable` with `memRead`=0 in T7.
- Unsupported opcode `IR`=32'hF8000000 → 4 cycles, no strobes in cycle 4, returns to T0.
- `halt`, `IR`=32'hD8000000 → `Run` drops after cycle 4 and stays 0 with all strobes 0 for 10 cycles; `clear` restarts at T0.
